// File: rtl/cdma_despreader.sv
// Chip integrator / majority slicer with lock tracking and MSB-first byte assembly.
// Define SOFT_OUT_EN to add the soft_o port carrying the per-symbol ones count.
module cdma_despreader #(
  parameter int CHIPS     = 31,
  parameter int STRONG_TH = 26,
  parameter int LOCK_N    = 4,
  parameter int UNLOCK_N  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       chip_i,
  input  logic       sync_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       lock_o
`ifdef SOFT_OUT_EN
  ,
  output logic [$clog2(CHIPS+1)-1:0] soft_o
`endif
);

  localparam int CW = $clog2(CHIPS + 1);
  localparam int RW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_chip_cnt;
  logic [CW-1:0]   r_ones;
  logic [RW-1:0]   r_run;
  logic [UW-1:0]   r_weak_run;
  logic [2:0]      r_bit_cnt;
  logic [6:0]      r_shift;
  logic            r_bit;
  logic            r_bit_valid;
  logic [7:0]      r_byte;
  logic            r_byte_valid;
  logic            r_lock;
`ifdef SOFT_OUT_EN
  logic [CW-1:0]   r_soft;
`endif

  logic [CW-1:0]   w_ones_final;
  logic            w_last_chip;
  logic            w_bit;
  logic            w_strong;

  // The current chip is folded in so the decision covers the full symbol.
  assign w_ones_final = r_ones + CW'(chip_i);
  assign w_last_chip  = (r_chip_cnt == CW'(CHIPS - 1));
  assign w_bit        = (w_ones_final > CW'(CHIPS / 2));
  assign w_strong     = (w_ones_final >= CW'(STRONG_TH)) ||
                        (w_ones_final <= CW'(CHIPS - STRONG_TH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= SEARCH;
      r_chip_cnt   <= '0;
      r_ones       <= '0;
      r_run        <= '0;
      r_weak_run   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_bit        <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_lock       <= 1'b0;
`ifdef SOFT_OUT_EN
      r_soft       <= '0;
`endif
    end else begin
      r_bit_valid  <= 1'b0;
      r_byte_valid <= 1'b0;
      if (sync_i) begin
        // Realignment aborts the partial symbol; a coincident chip starts the new one.
        r_ones     <= en_i ? CW'(chip_i) : '0;
        r_chip_cnt <= en_i ? CW'(1) : '0;
      end else if (en_i) begin
        if (w_last_chip) begin
          r_chip_cnt  <= '0;
          r_ones      <= '0;
          r_bit       <= w_bit;
          r_bit_valid <= 1'b1;
`ifdef SOFT_OUT_EN
          r_soft      <= w_ones_final;
`endif
          if (r_state == SEARCH) begin
            if (w_strong) begin
              if (r_run == RW'(LOCK_N - 1)) begin
                r_state    <= LOCKED;
                r_lock     <= 1'b1;
                r_run      <= '0;
                r_weak_run <= '0;
                r_bit_cnt  <= '0;
              end else begin
                r_run <= r_run + 1'b1;
              end
            end else begin
              r_run <= '0;
            end
          end else begin
            if (!w_strong && (r_weak_run == UW'(UNLOCK_N - 1))) begin
              // Losing lock drops the partial byte, including this symbol.
              r_state    <= SEARCH;
              r_lock     <= 1'b0;
              r_run      <= '0;
              r_weak_run <= '0;
              r_bit_cnt  <= '0;
            end else begin
              r_weak_run <= w_strong ? '0 : r_weak_run + 1'b1;
              r_shift    <= {r_shift[5:0], w_bit};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_byte       <= {r_shift, w_bit};
                r_byte_valid <= 1'b1;
              end
            end
          end
        end else begin
          r_chip_cnt <= r_chip_cnt + 1'b1;
          r_ones     <= w_ones_final;
        end
      end
    end
  end

  assign bit_o        = r_bit;
  assign bit_valid_o  = r_bit_valid;
  assign byte_o       = r_byte;
  assign byte_valid_o = r_byte_valid;
  assign lock_o       = r_lock;
`ifdef SOFT_OUT_EN
  assign soft_o       = r_soft;
`endif

endmodule

// File: tb/tb_cdma_despreader.sv
// Directed bench for cdma_despreader: reset, lock, byte assembly, weak decisions, sync, gaps.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cdma_despreader;

  localparam int CHIPS = 31;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       chip_i = 1'b0;
  logic       sync_i = 1'b0;
  logic       bit_o;
  logic       bit_valid_o;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       lock_o;
`ifdef SOFT_OUT_EN
  logic [4:0] soft_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int bv_seen = 0;
  int byv_seen = 0;

  cdma_despreader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .chip_i       (chip_i),
    .sync_i       (sync_i),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
`ifdef SOFT_OUT_EN
    .soft_o       (soft_o),
`endif
    .lock_o       (lock_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tally();
    if (bit_valid_o) bv_seen++;
    if (byte_valid_o) byv_seen++;
  endtask

  task automatic chip(input logic c);
    en_i = 1'b1; chip_i = c;
    @(negedge clk_i);
    en_i = 1'b0; chip_i = 1'b0;
    tally();
  endtask

  task automatic idle();
    en_i = 1'b0;
    @(negedge clk_i);
    tally();
  endtask

  // Ones first, then zeros; optional random idle cycles before each chip.
  task automatic symbol(input int ones, input bit gaps);
    for (int i = 0; i < CHIPS; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      chip(i < ones);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; sync_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({bit_o, bit_valid_o, byte_o, byte_valid_o, lock_o} !== 12'h000)
      $display("FAIL reset_outputs got %h expected 000", {bit_o, bit_valid_o, byte_o, byte_valid_o, lock_o});
    else pass_cnt++;
    symbol(31, 0);
    total_cnt++;
    if (bit_o !== 1'b1) $display("FAIL reset_first_bit got %b expected 1", bit_o); else pass_cnt++;
    for (int i = 0; i < 10; i++) chip(1'b1);
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({bit_o, bit_valid_o, byte_o, byte_valid_o, lock_o} !== 12'h000)
      $display("FAIL reset_async got %h expected 000", {bit_o, bit_valid_o, byte_o, byte_valid_o, lock_o});
    else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    bv_seen = 0;
    for (int i = 0; i < 30; i++) chip(1'b1);
    total_cnt++;
    if (bv_seen !== 0) $display("FAIL reset_partial_discard got %0d pulses expected 0", bv_seen); else pass_cnt++;
    chip(1'b1);
    total_cnt++;
    if ({bit_valid_o, bit_o} !== 2'b11) $display("FAIL reset_bit_latency got %b expected 11", {bit_valid_o, bit_o}); else pass_cnt++;
    idle();
    total_cnt++;
    if (bit_valid_o !== 1'b0) $display("FAIL bit_valid_one_cycle got %b expected 0", bit_valid_o); else pass_cnt++;
    $display("test_reset done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 3; k++) symbol(31, 0);
    symbol(16, 0);
    total_cnt++;
    if ({lock_o, bit_o} !== 2'b01) $display("FAIL lock_weak_break got lock,bit=%b expected 01", {lock_o, bit_o}); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      symbol(31, 0);
      total_cnt++;
      if (lock_o !== (k == 3)) $display("FAIL lock_acquire sym%0d got %b expected %b", k, lock_o, k == 3); else pass_cnt++;
    end
    $display("test_lock done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_byte();
    logic [7:0] pattern;
    pattern = 8'hA5;
    byv_seen = 0;
    total_cnt++;
    if (byte_o !== 8'h00) $display("FAIL byte_initial got %h expected 00", byte_o); else pass_cnt++;
    for (int k = 7; k >= 0; k--) symbol(pattern[k] ? 31 : 0, 0);
    total_cnt++;
    if ({byte_valid_o, bit_valid_o} !== 2'b11) $display("FAIL byte_valid_coincident got %b expected 11", {byte_valid_o, bit_valid_o}); else pass_cnt++;
    total_cnt++;
    if (byte_o !== 8'hA5) $display("FAIL byte_value got %h expected a5", byte_o); else pass_cnt++;
    total_cnt++;
    if (byv_seen !== 1) $display("FAIL byte_pulse_count got %0d expected 1", byv_seen); else pass_cnt++;
    idle();
    total_cnt++;
    if ({byte_valid_o, byte_o} !== {1'b0, 8'hA5}) $display("FAIL byte_hold got %h expected 0a5", {byte_valid_o, byte_o}); else pass_cnt++;
    $display("test_byte done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_noisy();
    symbol(16, 0);
    total_cnt++;
    if ({bit_o, lock_o} !== 2'b11) $display("FAIL noisy_16 got bit,lock=%b expected 11", {bit_o, lock_o}); else pass_cnt++;
    symbol(31, 0);
    symbol(15, 0);
    total_cnt++;
    if ({bit_o, lock_o} !== 2'b01) $display("FAIL noisy_15_retain got bit,lock=%b expected 01", {bit_o, lock_o}); else pass_cnt++;
    symbol(15, 0);
    total_cnt++;
    if ({bit_o, lock_o} !== 2'b00) $display("FAIL noisy_unlock got bit,lock=%b expected 00", {bit_o, lock_o}); else pass_cnt++;
    $display("test_noisy done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_sync();
    do_reset();
    for (int i = 0; i < 20; i++) chip(1'b1);
    bv_seen = 0;
    sync_i = 1'b1;
    chip(1'b1);
    sync_i = 1'b0;
    for (int i = 0; i < 15; i++) chip(1'b1);
    for (int i = 0; i < 14; i++) chip(1'b0);
    total_cnt++;
    if (bv_seen !== 0) $display("FAIL sync_no_pulse got %0d pulses expected 0", bv_seen); else pass_cnt++;
    chip(1'b0);
    total_cnt++;
    if ({bit_valid_o, bit_o} !== 2'b11) $display("FAIL sync_symbol_end got valid,bit=%b expected 11", {bit_valid_o, bit_o}); else pass_cnt++;
    $display("test_sync done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_gaps();
    int ones_tbl[8] = '{31, 0, 16, 15, 27, 4, 29, 2};
    do_reset();
    for (int s = 0; s < 8; s++) begin
      symbol(ones_tbl[s], 1);
      total_cnt++;
      if ({bit_valid_o, bit_o} !== {1'b1, ones_tbl[s] > 15})
        $display("FAIL gaps_bit sym%0d got valid,bit=%b expected 1%b", s, {bit_valid_o, bit_o}, ones_tbl[s] > 15);
      else pass_cnt++;
`ifdef SOFT_OUT_EN
      total_cnt++;
      if (soft_o !== 5'(ones_tbl[s])) $display("FAIL gaps_soft sym%0d got %0d expected %0d", s, soft_o, ones_tbl[s]); else pass_cnt++;
`endif
      if (s == 5) begin
        total_cnt++;
        if (lock_o !== 1'b0) $display("FAIL gaps_no_lock got %b expected 0", lock_o); else pass_cnt++;
      end
    end
    total_cnt++;
    if (lock_o !== 1'b1) $display("FAIL gaps_lock got %b expected 1", lock_o); else pass_cnt++;
    $display("test_gaps done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_byte();
    test_noisy();
    test_sync();
    test_gaps();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
